mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 99 +++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - instruction-fetch / data arbiter for a single shared memory port
// Data wins contention until STARVE_MAX consecutive data grants have passed a waiting fetch.
module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_func3,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            r_state;
    logic [3:0]        r_starve_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [2:0]        r_mem_func3;
    logic              r_mem_we;
    logic              w_data_grant;
    logic              w_fetch_grant;

    assign w_data_grant  = d_req && (!if_req || (r_starve_cnt < STARVE_LIM));
    assign w_fetch_grant = if_req && !w_data_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= 4'd0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
            r_mem_func3  <= 3'd0;
            r_mem_we     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_data_grant) begin
                        r_state     <= DATA;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_func3 <= d_func3;
                        r_mem_we    <= d_we;
                        // Only data grants that overtake a waiting fetch count toward starvation
                        if (if_req && (r_starve_cnt < STARVE_LIM))
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                    end else if (w_fetch_grant) begin
                        r_state      <= FETCH;
                        r_mem_addr   <= if_addr;
                        r_mem_func3  <= 3'b010;
                        r_mem_we     <= 1'b0;
                        r_starve_cnt <= 4'd0;
                    end
                end
                FETCH, DATA: begin
                    if (mem_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req   = (r_state != IDLE);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_func3 = r_mem_func3;

    assign if_valid  = (r_state == FETCH) && mem_ready;
    assign d_valid   = (r_state == DATA) && mem_ready;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign if_stall  = if_req && !if_valid;
    assign d_stall   = d_req && !d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW   = 12;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_valid;
    logic          if_stall;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [2:0]    d_func3;
    logic [31:0]   d_rdata;
    logic          d_valid;
    logic          d_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [2:0]    mem_func3;
    logic [31:0]   mem_rdata;
    logic          mem_ready;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_func3(d_func3), .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_func3(mem_func3),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = 32'd0; d_func3 = 3'd0;
        mem_rdata = 32'd0; mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({mem_req, mem_we, if_valid, d_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000", {mem_req, mem_we, if_valid, d_valid});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== 32'd0 || mem_func3 !== 3'd0) begin
            errors++; $display("FAIL reset_fields: got addr=%h wdata=%h f3=%b want 0", mem_addr, mem_wdata, mem_func3);
        end
    endtask

    task automatic test_fetch();
        do_reset();
        if_req = 1'b1; if_addr = 12'h010;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h010 || mem_we !== 1'b0 || mem_func3 !== 3'b010) begin
            errors++; $display("FAIL fetch_grant: got req=%b addr=%h we=%b f3=%b want 1 010 0 010", mem_req, mem_addr, mem_we, mem_func3);
        end
        checks++;
        if (if_stall !== 1'b1 || if_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_wait: got stall=%b valid=%b want 1 0", if_stall, if_valid);
        end
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h00500093;
        #1;
        checks++;
        if (if_valid !== 1'b1 || if_stall !== 1'b0 || if_rdata !== 32'h00500093) begin
            errors++; $display("FAIL fetch_done: got valid=%b stall=%b rdata=%h want 1 0 00500093", if_valid, if_stall, if_rdata);
        end
        tick();
        mem_ready = 1'b0; if_req = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_idle: got req=%b valid=%b want 0 0", mem_req, if_valid);
        end
    endtask

    task automatic test_contention();
        do_reset();
        if_req = 1'b1; if_addr = 12'h03c;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h100; d_func3 = 3'b010;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h100 || if_stall !== 1'b1 || d_stall !== 1'b1) begin
            errors++; $display("FAIL cont_data_first: got req=%b addr=%h istall=%b dstall=%b want 1 100 1 1", mem_req, mem_addr, if_stall, d_stall);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (d_valid !== 1'b1 || if_valid !== 1'b0) begin
            errors++; $display("FAIL cont_dvalid: got d=%b i=%b want 1 0", d_valid, if_valid);
        end
        tick();
        mem_ready = 1'b0; d_req = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL cont_gap: got req=%b want 0", mem_req);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h03c || mem_func3 !== 3'b010 || mem_we !== 1'b0) begin
            errors++; $display("FAIL cont_fetch: got req=%b addr=%h f3=%b we=%b want 1 03c 010 0", mem_req, mem_addr, mem_func3, mem_we);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b1) begin
            errors++; $display("FAIL cont_ivalid: got %b want 1", if_valid);
        end
        tick();
        mem_ready = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_store();
        int pulses;
        do_reset();
        pulses = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h204; d_wdata = 32'hDEADBEEF; d_func3 = 3'b000;
        tick();
        d_wdata = 32'd0; d_addr = 12'h000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 12'h204 || mem_func3 !== 3'b000 || d_stall !== 1'b1) begin
                errors++; $display("FAIL store_hold: got we=%b wdata=%h addr=%h f3=%b stall=%b", mem_we, mem_wdata, mem_addr, mem_func3, d_stall);
            end
            if (d_valid === 1'b1) pulses++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        if (d_valid === 1'b1) pulses++;
        checks++;
        if (mem_wdata !== 32'hDEADBEEF || mem_we !== 1'b1) begin
            errors++; $display("FAIL store_ready: got wdata=%h we=%b want deadbeef 1", mem_wdata, mem_we);
        end
        tick();
        mem_ready = 1'b0; d_req = 1'b0;
        #1;
        if (d_valid === 1'b1) pulses++;
        checks++;
        if (pulses != 1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL store_pulse: got pulses=%0d req=%b want 1 0", pulses, mem_req);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h008; d_func3 = 3'b010;
        tick();
        tick();
        tick();
        rst = 1'b1; d_req = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || d_valid !== 1'b0 || mem_addr !== '0) begin
            errors++; $display("FAIL rstmid_abort: got req=%b dvalid=%b addr=%h want 0 0 000", mem_req, d_valid, mem_addr);
        end
        tick();
        rst = 1'b0;
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        #1;
        checks++;
        if (d_valid !== 1'b0 || if_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL rstmid_spurious: got d=%b i=%b req=%b want 0 0 0", d_valid, if_valid, mem_req);
        end
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic test_idle_ready();
        do_reset();
        mem_ready = 1'b1; mem_rdata = $urandom;
        #1;
        checks++;
        if ({mem_req, mem_we, if_valid, d_valid, if_stall, d_stall} !== 6'b0 || mem_addr !== '0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL idle_ready: got req=%b we=%b iv=%b dv=%b addr=%h", mem_req, mem_we, if_valid, d_valid, mem_addr);
        end
        tick();
        checks++;
        if (mem_req !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0) begin
            errors++; $display("FAIL idle_ready_next: got req=%b iv=%b dv=%b want 0", mem_req, if_valid, d_valid);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_starvation();
        int   grants;
        logic prev_req;
        logic want_fetch;
        logic got_fetch;
        do_reset();
        if_req = 1'b1; if_addr = 12'h040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h200; d_func3 = 3'b010;
        grants = 0; prev_req = 1'b0;
        for (int c = 0; c < 100 && grants < 15; c++) begin
            tick();
            mem_ready = mem_req;
            if (mem_req === 1'b1 && prev_req !== 1'b1) begin
                want_fetch = ((grants % (SMAX + 1)) == SMAX);
                got_fetch  = (mem_addr == 12'h040);
                checks++;
                if (got_fetch !== want_fetch) begin
                    errors++; $display("FAIL starve_seq: grant %0d got fetch=%b want %b", grants, got_fetch, want_fetch);
                end
                grants++;
            end
            prev_req = mem_req;
        end
        mem_ready = 1'b0;
        checks++;
        if (grants < 15) begin
            errors++; $display("FAIL starve_count: got %0d grants want 15", grants);
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int busy, done_prev, kind, lat, cnt, starve, pred, if_dn, d_dn;
        logic s_if, s_d, s_we;
        logic [AW-1:0] s_ia, s_da, e_addr;
        logic [31:0] s_wd, e_wdata;
        logic [2:0] s_f3, e_f3;
        logic e_we, exp_iv, exp_dv;
        do_reset();
        busy = 0; done_prev = 0; kind = 0; lat = 1; cnt = 0; starve = 0; if_dn = 0; d_dn = 0;
        e_addr = '0; e_wdata = 32'd0; e_f3 = 3'd0; e_we = 1'b0;
        s_if = 1'b0; s_d = 1'b0; s_we = 1'b0; s_ia = '0; s_da = '0; s_wd = 32'd0; s_f3 = 3'd0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (done_prev != 0) begin
                busy = 0;
            end else if (busy == 0) begin
                pred = 0;
                if (s_d && (!s_if || starve < SMAX)) pred = 2;
                else if (s_if) pred = 1;
                if (pred == 2) begin
                    e_addr = s_da; e_wdata = s_wd; e_we = s_we; e_f3 = s_f3;
                    if (s_if) starve = (starve < SMAX) ? starve + 1 : SMAX;
                end else if (pred == 1) begin
                    e_addr = s_ia; e_we = 1'b0; e_f3 = 3'b010; starve = 0;
                end
                if (pred != 0) begin
                    busy = 1; kind = pred; lat = $urandom_range(1, 3); cnt = 0;
                end
            end
            done_prev = 0;
            checks++;
            if (mem_req !== (busy != 0) || mem_addr !== e_addr || mem_we !== e_we || mem_func3 !== e_f3 || mem_wdata !== e_wdata) begin
                errors++;
                $display("FAIL rand_port c=%0d: got req=%b addr=%h we=%b f3=%b wd=%h want %b %h %b %b %h",
                         c, mem_req, mem_addr, mem_we, mem_func3, mem_wdata, (busy != 0), e_addr, e_we, e_f3, e_wdata);
            end
            if (if_dn != 0) begin
                if_dn = 0; if_req = 1'($urandom_range(0, 1)); if_addr = AW'($urandom);
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = AW'($urandom);
            end
            if (d_dn != 0) begin
                d_dn = 0; d_req = 1'($urandom_range(0, 1));
                d_we = 1'($urandom); d_addr = AW'($urandom); d_wdata = $urandom; d_func3 = 3'($urandom);
            end else if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = AW'($urandom); d_wdata = $urandom; d_func3 = 3'($urandom);
            end else if (d_req && $urandom_range(0, 3) == 0) begin
                d_wdata = $urandom;
            end
            if (busy != 0) begin
                cnt++;
                mem_ready = (cnt == lat);
            end else begin
                mem_ready = ($urandom_range(0, 4) == 0);
            end
            mem_rdata = $urandom;
            #1;
            exp_iv = (busy != 0) && (kind == 1) && mem_ready;
            exp_dv = (busy != 0) && (kind == 2) && mem_ready;
            checks++;
            if (if_valid !== exp_iv || d_valid !== exp_dv || if_rdata !== mem_rdata || d_rdata !== mem_rdata) begin
                errors++; $display("FAIL rand_valid c=%0d: got iv=%b dv=%b want %b %b", c, if_valid, d_valid, exp_iv, exp_dv);
            end
            checks++;
            if (if_stall !== (if_req && !exp_iv) || d_stall !== (d_req && !exp_dv)) begin
                errors++; $display("FAIL rand_stall c=%0d: got is=%b ds=%b", c, if_stall, d_stall);
            end
            if (exp_iv) begin if_dn = 1; done_prev = 1; end
            if (exp_dv) begin d_dn = 1; done_prev = 1; end
            s_if = if_req; s_d = d_req; s_we = d_we; s_ia = if_addr; s_da = d_addr; s_wd = d_wdata; s_f3 = d_func3;
        end
        mem_ready = 1'b0; if_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_store();
        test_reset_mid();
        test_idle_ready();
        test_starvation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
